// File: rtl/muldiv_if.sv
// Pipeline-facing bundle of the iterative multiply/divide unit: E-stage issue,
// Decode hazard sources, and the register-file write-port handshake.
interface muldiv_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned REG_AW = 3
);
  logic              start_e;
  logic [1:0]        op_e;
  logic [WIDTH-1:0]  src_a_e;
  logic [WIDTH-1:0]  src_b_e;
  logic [REG_AW-1:0] rd_e;
  logic              flush_e;
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic              wb_grant;
  logic              stall_req;
  logic              busy;
  logic              wb_req;
  logic [REG_AW-1:0] wb_rd;
  logic [WIDTH-1:0]  wb_data;

  modport master (
    output start_e, op_e, src_a_e, src_b_e, rd_e, flush_e, rs1_d, rs2_d, wb_grant,
    input  stall_req, busy, wb_req, wb_rd, wb_data
  );

  modport slave (
    input  start_e, op_e, src_a_e, src_b_e, rd_e, flush_e, rs1_d, rs2_d, wb_grant,
    output stall_req, busy, wb_req, wb_rd, wb_data
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit beside Execute: one op at a time, WIDTH
// RUN cycles, then holds its result on the write port until granted.
module muldiv_sequencer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned REG_AW = 3
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StWb} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [REG_AW-1:0]   pend_rd_q, pend_rd_d;
  logic                sb_valid_q, sb_valid_d;

  logic             accept;
  logic             div_zero;
  logic             last_iter;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic             raw_hazard;
  logic             struct_hazard;

  assign accept    = bus.start_e && !bus.flush_e && (bus.rd_e != '0);
  assign div_zero  = bus.op_e[1] && (bus.src_b_e == '0);
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  // acc_q is {product high, multiplier/product low} for MUL, {remainder, quotient} for DIV
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = !div_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      pend_rd_q  <= '0;
      sb_valid_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      pend_rd_q  <= pend_rd_d;
      sb_valid_q <= sb_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = div_zero ? StWb : StRun;
      StRun:  if (last_iter) state_d = StWb;
      StWb:   if (bus.wb_grant) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    pend_rd_d  = pend_rd_q;
    sb_valid_d = sb_valid_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d       = bus.op_e;
          cnt_d      = '0;
          pend_rd_d  = bus.rd_e;
          sb_valid_d = 1'b1;
          if (bus.op_e[1]) begin
            opnd_d = bus.src_b_e;
            // Divide by zero lands directly in the result form: quotient all ones, rem = dividend
            acc_d  = div_zero ? {bus.src_a_e, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, bus.src_a_e};
          end else begin
            opnd_d = bus.src_a_e;
            acc_d  = {{WIDTH{1'b0}}, bus.src_b_e};
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (op_q[1]) begin
          acc_d = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                         : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        end
      end
      StWb: begin
        if (bus.wb_grant) sb_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign raw_hazard = sb_valid_q && (pend_rd_q != '0) &&
                      ((bus.rs1_d == pend_rd_q) || (bus.rs2_d == pend_rd_q));
  assign struct_hazard = (state_q != StIdle) && bus.start_e && !bus.flush_e;

  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.wb_req    = (state_q == StWb);
    bus.stall_req = raw_hazard || struct_hazard;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    if (state_q == StWb) begin
      bus.wb_rd   = pend_rd_q;
      // op[0] selects the high half: MULHU product high, REMU remainder
      bus.wb_data = op_q[0] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of expected write-backs,
// hazard/stall checks, write-port hold, back-to-back issue and reset abort.
module tb_muldiv_sequencer;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W), .REG_AW(AW)) bus ();

  muldiv_sequencer #(.WIDTH(W), .REG_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [W-1:0]  data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (b == '0) ? {W{1'b1}} : a / b;
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_e = 1'b0;
    bus.op_e    = '0;
    bus.src_a_e = '0;
    bus.src_b_e = '0;
    bus.rd_e    = '0;
    bus.flush_e = 1'b0;
    bus.rs1_d   = '0;
    bus.rs2_d   = '0;
  endtask

  // Drive one op for a single cycle; returns one cycle after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] rd, input logic [W-1:0] exp_data);
    exp_t e;
    bus.start_e = 1'b1;
    bus.op_e    = op;
    bus.src_a_e = a;
    bus.src_b_e = b;
    bus.rd_e    = rd;
    step();
    bus.start_e = 1'b0;
    e.rd   = rd;
    e.data = exp_data;
    sb_q.push_back(e);
  endtask

  // lat counts cycles after the accept edge (1 = first cycle after accept).
  task automatic wait_wb(input int budget, output int lat, output logic seen);
    lat = 1;
    while (bus.wb_req !== 1'b1 && lat < budget) begin
      step();
      lat++;
    end
    seen = (bus.wb_req === 1'b1);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.wb_grant = 1'b0;
    idle_inputs();
    step();
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", bus.busy); end
    checks++; if (bus.wb_req !== 1'b0) begin errors++; $display("FAIL reset_wb_req: got %b, want 0", bus.wb_req); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, want 0", bus.stall_req); end
    checks++; if (bus.wb_rd !== '0) begin errors++; $display("FAIL reset_wb_rd: got %h, want 0", bus.wb_rd); end
    checks++; if (bus.wb_data !== '0) begin errors++; $display("FAIL reset_wb_data: got %h, want 0", bus.wb_data); end
    rst = 1'b0;
    step();
  endtask

  // Table-driven ops with grant tied high; checks latency, result, and busy drop.
  task automatic test_mul_div();
    logic [1:0]    ops  [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01};
    logic [W-1:0]  as   [8] = '{16'd300, 16'hFFFF, 16'hFFFF, 16'd1000, 16'd1000, 16'h1234,
                                16'h1234, 16'd300};
    logic [W-1:0]  bs   [8] = '{16'd200, 16'hFFFF, 16'hFFFF, 16'd7, 16'd7, 16'h0, 16'h0,
                                16'd200};
    logic [AW-1:0] rds  [8] = '{3'd3, 3'd1, 3'd2, 3'd6, 3'd7, 3'd3, 3'd4, 3'd5};
    logic [W-1:0]  exps [8] = '{16'hEA60, 16'hFFFE, 16'h0001, 16'h008E, 16'h0006, 16'hFFFF,
                                16'h1234, 16'h0000};
    int            lats [8] = '{17, 17, 17, 17, 17, 1, 1, 17};
    int   lat;
    logic seen;
    exp_t e;
    bus.wb_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i], rds[i], exps[i]);
      wait_wb(40, lat, seen);
      e = sb_q.pop_front();
      checks++;
      if (!seen || lat != lats[i]) begin
        errors++;
        $display("FAIL op%0d_latency: got %0d cycles (seen=%b), want %0d", i, lat, seen, lats[i]);
      end
      checks++; if (bus.wb_data !== e.data) begin errors++; $display("FAIL op%0d_data: got %h, want %h", i, bus.wb_data, e.data); end
      checks++; if (bus.wb_rd !== e.rd) begin errors++; $display("FAIL op%0d_rd: got %0d, want %0d", i, bus.wb_rd, e.rd); end
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL op%0d_busy_after_grant: got %b, want 0", i, bus.busy); end
    end
  endtask

  task automatic test_random();
    int   lat;
    logic seen;
    exp_t e;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic [AW-1:0] rd;
    bus.wb_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom);
      a  = 16'($urandom);
      b  = (i % 4 == 3) ? '0 : 16'($urandom_range(1, 65535));
      if (i % 4 == 3) op[1] = 1'b1;
      rd = 3'($urandom_range(1, 7));
      issue(op, a, b, rd, model(op, a, b));
      wait_wb(40, lat, seen);
      e = sb_q.pop_front();
      checks++;
      if (!seen || lat != ((op[1] && b == '0) ? 1 : 17)) begin
        errors++;
        $display("FAIL rand%0d_latency: got %0d cycles (seen=%b)", i, lat, seen);
      end
      checks++;
      if (bus.wb_data !== e.data || bus.wb_rd !== e.rd) begin
        errors++;
        $display("FAIL rand%0d_result op=%0d a=%h b=%h: got rd=%0d data=%h, want rd=%0d data=%h",
                 i, op, a, b, bus.wb_rd, bus.wb_data, e.rd, e.data);
      end
      step();
    end
  endtask

  // RAW stall on pending rd=5 through RUN, plus a structural second issue mid-RUN.
  task automatic test_raw_stall();
    logic exp_st;
    bus.wb_grant = 1'b0;
    idle_inputs();
    issue(2'b00, 16'd9, 16'd9, 3'd5, 16'd81);
    for (int i = 0; i < int'(W); i++) begin
      bus.start_e = 1'b0;
      if (i == 3) begin
        bus.rs1_d = 3'd0; bus.rs2_d = 3'd4; exp_st = 1'b0;
      end else if (i == 6) begin
        bus.rs1_d = 3'd0; bus.rs2_d = 3'd4; exp_st = 1'b1;
        bus.start_e = 1'b1; bus.op_e = 2'b00; bus.rd_e = 3'd6;
        bus.src_a_e = 16'd2; bus.src_b_e = 16'd2;
      end else begin
        bus.rs1_d = 3'd5; bus.rs2_d = 3'd0; exp_st = 1'b1;
      end
      #1;
      checks++;
      if (bus.stall_req !== exp_st) begin
        errors++;
        $display("FAIL run_stall_cycle%0d: got %b, want %b", i, bus.stall_req, exp_st);
      end
      step();
    end
    bus.start_e = 1'b0;
    bus.rs1_d   = 3'd5;
    bus.rs2_d   = 3'd0;
  endtask

  // Continues from WB of the rd=5 op: hold 3 cycles, grant with a coincident start.
  task automatic test_wb_hold_back_to_back();
    exp_t e;
    exp_t e2;
    int   lat;
    logic seen;
    e = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.wb_req !== 1'b1 || bus.wb_rd !== e.rd || bus.wb_data !== e.data) begin
        errors++;
        $display("FAIL wb_hold%0d: got req=%b rd=%0d data=%h, want req=1 rd=%0d data=%h",
                 k, bus.wb_req, bus.wb_rd, bus.wb_data, e.rd, e.data);
      end
      checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL wb_hold_stall%0d: got %b, want 1", k, bus.stall_req); end
      step();
    end
    bus.wb_grant = 1'b1;
    bus.start_e  = 1'b1;
    bus.op_e     = 2'b00;
    bus.src_a_e  = 16'd12;
    bus.src_b_e  = 16'd11;
    bus.rd_e     = 3'd2;
    #1;
    checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL grant_cycle_stall: got %b, want 1", bus.stall_req); end
    checks++; if (bus.wb_data !== e.data) begin errors++; $display("FAIL grant_cycle_data: got %h, want %h", bus.wb_data, e.data); end
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL after_grant_busy: got %b, want 0", bus.busy); end
    checks++; if (bus.wb_req !== 1'b0) begin errors++; $display("FAIL after_grant_wb_req: got %b, want 0", bus.wb_req); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL after_grant_stall: got %b, want 0", bus.stall_req); end
    e2.rd   = 3'd2;
    e2.data = 16'd132;
    sb_q.push_back(e2);
    step();
    bus.start_e = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy: got %b, want 1", bus.busy); end
    wait_wb(40, lat, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || lat != 17 || bus.wb_data !== e.data || bus.wb_rd !== e.rd) begin
      errors++;
      $display("FAIL b2b_result: got lat=%0d seen=%b rd=%0d data=%h, want lat=17 rd=%0d data=%h",
               lat, seen, bus.wb_rd, bus.wb_data, e.rd, e.data);
    end
    step();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d, want 0", sb_q.size()); end
  endtask

  task automatic test_reset_abort();
    int req_seen;
    bus.wb_grant = 1'b1;
    idle_inputs();
    bus.start_e = 1'b1;
    bus.op_e    = 2'b00;
    bus.src_a_e = 16'd100;
    bus.src_b_e = 16'd100;
    bus.rd_e    = 3'd4;
    step();
    bus.start_e = 1'b0;
    bus.rs1_d   = 3'd4;
    repeat (8) step();
    rst = 1'b1;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, want 0", bus.busy); end
    checks++; if (bus.wb_req !== 1'b0) begin errors++; $display("FAIL abort_wb_req: got %b, want 0", bus.wb_req); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b, want 0", bus.stall_req); end
    rst = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.wb_req === 1'b1) req_seen++;
    end
    checks++; if (req_seen != 0) begin errors++; $display("FAIL abort_late_wb_req: got %0d cycles, want 0", req_seen); end
    bus.start_e = 1'b1;
    bus.flush_e = 1'b1;
    bus.rd_e    = 3'd3;
    #1;
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL flush_start_stall: got %b, want 0", bus.stall_req); end
    step();
    bus.flush_e = 1'b0;
    bus.rd_e    = 3'd0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_ignored_busy: got %b, want 0", bus.busy); end
    step();
    bus.start_e = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rd0_ignored_busy: got %b, want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_mul_div();
    test_random();
    test_raw_stall();
    test_wb_hold_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with its own sequencing FSM, sitting beside the Execute stage of the 8-register pipeline.
- Accepts one operation from E, runs it over WIDTH cycles, then requests the register-file write port and holds its result until granted.
- Keeps a one-entry scoreboard on the pending destination register.
- Sends stall requests to the pipeline hazard logic: RAW on the pending rd, and structural conflict on a second issue.

Parameters:
- WIDTH, 16, operand/result width in bits; iteration count of RUN.
- REG_AW, 3, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start_e  in  1  E stage holds a mul/div op this cycle.
- op_e  in  2  00 MUL (low half), 01 MULHU (unsigned high half), 10 DIVU, 11 REMU.
- src_a_e  in  WIDTH  forwarded operand A (dividend/multiplicand).
- src_b_e  in  WIDTH  forwarded operand B (divisor/multiplier).
- rd_e  in  REG_AW  destination register.
- flush_e  in  1  E stage being flushed this cycle (branch taken).
- rs1_d  in  REG_AW  Decode source 1.
- rs2_d  in  REG_AW  Decode source 2.
- wb_grant  in  1  write port granted to this unit this cycle.
- stall_req  out  1  request stall of F/D (and hold of E for structural case).
- busy  out  1  state != IDLE.
- wb_req  out  1  result valid, requesting write port.
- wb_rd  out  REG_AW  destination of pending result.
- wb_data  out  WIDTH  result.

Behaviour:
- Reset:
  - state=IDLE.
  - busy, wb_req, stall_req = 0.
  - wb_rd = 0, wb_data = 0.
  - Scoreboard invalid; iteration counter = 0.
  - Reset in any state (including mid-RUN or WB) aborts the operation with no write request.
- States: IDLE, RUN, WB.
- IDLE:
  - Accept when start_e=1, flush_e=0 and rd_e!=0.
  - On accept: latch op, operands and rd; set scoreboard valid with pend_rd=rd_e; counter=0.
  - Next state is RUN, or WB directly for divide-by-zero.
  - start_e with rd_e==0, or with flush_e=1: ignored, stays IDLE, no stall.
- RUN:
  - Multiply: one shift-add step per cycle on an unsigned 2*WIDTH product register.
  - Divide: one restoring step per cycle on an unsigned quotient/remainder pair.
  - After WIDTH iterations (counter = WIDTH-1 on the last step) → WB.
- Latency: accept at cycle N; RUN occupies cycles N+1..N+WIDTH; wb_req=1 from cycle N+WIDTH+1.
- Divide by zero (src_b_e==0 with op 10/11):
  - DIVU result = all ones; REMU result = dividend.
  - Goes to WB at N+1, no RUN cycles.
- Result selection:
  - MUL → product[WIDTH-1:0].
  - MULHU → product[2*WIDTH-1:WIDTH].
  - DIVU → quotient.
  - REMU → remainder.
- WB:
  - wb_req=1; wb_rd and wb_data held stable until the grant.
  - On wb_grant=1: write occurs that cycle; next state IDLE, scoreboard cleared, wb_req=0 next cycle.
  - wb_grant while not in WB is ignored.
- stall_req is combinational and asserted when:
  - (a) scoreboard valid and (rs1_d==pend_rd or rs2_d==pend_rd), with pend_rd != 0; or
  - (b) state != IDLE and start_e=1 and flush_e=0 (structural: second op must wait).
- Grant cycle: in the cycle wb_grant=1, condition (a) still holds. The register value becomes readable through writeback forwarding the following cycle.
- A new start_e coincident with wb_grant is not accepted (state still WB): stall_req=1, accepted next cycle from IDLE.
- flush_e never aborts an accepted operation: the op was accepted before any later branch resolved.

Test Plan:
- MUL 300*200 (WIDTH=16), rd=3, wb_grant tied 1 → wb_req rises exactly 17 cycles after the accept edge; wb_data=0xEA60, wb_rd=3; busy drops the next cycle.
- MULHU 0xFFFF*0xFFFF → wb_data=0xFFFE. Then MUL on the same operands → 0x0001.
- DIVU 1000/7 → 142 (0x008E); REMU 1000/7 → 6. DIVU 0x1234/0 → 0xFFFF with wb_req one cycle after accept; REMU 0x1234/0 → 0x1234.
- Pending rd=5, rs1_d=5 during RUN → stall_req=1 every cycle through the grant cycle, 0 after. rs1_d=0, rs2_d=4 → stall_req=0. start_e=1 while RUN → stall_req=1, op not accepted.
- WB with wb_grant held 0 for 3 cycles → wb_req, wb_rd, wb_data stable. Grant on the 4th cycle → IDLE next cycle. start_e same cycle as grant → accepted one cycle later.
- rst=1 at RUN iteration 8 → next cycle: busy=0, wb_req=0, stall_req=0; no write request ever issued. start_e with flush_e=1 → ignored, busy stays 0.
